// File: rtl/popcount_mon_pkg.sv
// Shared definitions for the approximate-popcount error monitor:
// default sizes, the window FSM state type and the absolute-difference helper.
package popcount_mon_pkg;

  localparam int N_IN_DEF     = 8;
  localparam int CW_DEF       = 4;
  localparam int WIN_LOG2_DEF = 8;

  // Working width of abs_diff; callers zero-extend into it and truncate the result.
  localparam int ABS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    logic signed [ABS_W:0] d;
    logic        [ABS_W:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = (d < 0) ? -d : d;
    return m[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/popcount_err_monitor_if.sv
// Sample stream and result record bundle between the monitor and its
// producer/consumer; master is the driving side, slave is the monitor.
interface popcount_err_monitor_if
  import popcount_mon_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int CW       = CW_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN-1:0]        in_vec;
  logic [CW-1:0]          in_approx;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIN_LOG2+CW-1:0] err_sum;
  logic [CW-1:0]          err_max;
  logic [WIN_LOG2:0]      err_cnt;

  modport master (
    output in_valid, in_vec, in_approx, res_ready,
    input  in_ready, res_valid, err_sum, err_max, err_cnt
  );

  modport slave (
    input  in_valid, in_vec, in_approx, res_ready,
    output in_ready, res_valid, err_sum, err_max, err_cnt
  );

endinterface

// File: rtl/popcount_exact.sv
// Golden population counter used as the reference in the accept stage.
module popcount_exact
  import popcount_mon_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic [N_IN-1:0] vec,
  output logic [CW-1:0]   cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/popcount_err_monitor.sv
// Windowed error monitor for an approximate popcount: one accept stage computes
// |approx - exact|, the next edge folds it into sum/max/mismatch accumulators.
module popcount_err_monitor
  import popcount_mon_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int CW       = CW_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  popcount_err_monitor_if.slave   bus
);

  localparam int              SUM_W    = WIN_LOG2 + CW;
  localparam int              CNT_W    = WIN_LOG2 + 1;
  localparam int              WIN_SIZE = 1 << WIN_LOG2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_SIZE - 1);

  function automatic logic [CW-1:0] max_mag(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    return (b > a) ? b : a;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             busy_q;

  logic [CW-1:0]    exact_c;
  logic [ABS_W-1:0] diff_full;
  logic [CW-1:0]    diff_c;
  logic             xfer;
  logic             last_xfer;

  logic             vld_p0;
  logic [CW-1:0]    diff_p0;
  logic             mis_p0;

  logic [SUM_W-1:0] err_sum_q;
  logic [CW-1:0]    err_max_q;
  logic [CNT_W-1:0] err_cnt_q;

  popcount_exact #(
    .N_IN (N_IN),
    .CW   (CW)
  ) u_exact (
    .vec (bus.in_vec),
    .cnt (exact_c)
  );

  // Inputs are below 2^CW, so the wide magnitude always fits in CW bits.
  assign diff_full = abs_diff(ABS_W'(bus.in_approx), ABS_W'(exact_c));
  assign diff_c    = diff_full[CW-1:0];

  assign xfer      = bus.in_valid & in_ready_q;
  assign last_xfer = xfer & (sample_cnt == LAST_IDX);

  // ---- accept stage p0: difference captured on the transfer edge ----
  always_ff @(posedge clk) begin
    if (xfer) begin
      diff_p0 <= diff_c;
      mis_p0  <= |diff_c;
    end
  end

  // ---- control, p0 valid and accumulators ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      vld_p0      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
      err_cnt_q   <= '0;
    end else if (abort) begin
      state       <= IDLE;
      vld_p0      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vld_p0 <= xfer;

      if (vld_p0) begin
        err_sum_q <= err_sum_q + SUM_W'(diff_p0);
        err_max_q <= max_mag(err_max_q, diff_p0);
        err_cnt_q <= err_cnt_q + CNT_W'(mis_p0);
      end

      case (state)
        IDLE: begin
          if (start) begin
            err_sum_q  <= '0;
            err_max_q  <= '0;
            err_cnt_q  <= '0;
            sample_cnt <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            sample_cnt <= sample_cnt + 1'b1;
          end
          // Dropping ready on this edge guarantees nothing past the window is taken.
          if (last_xfer) begin
            in_ready_q <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p0) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // Accumulators settle on DONE entry; the record is offered one edge later.
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
          end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.err_sum   = err_sum_q;
  assign bus.err_max   = err_max_q;
  assign bus.err_cnt   = err_cnt_q;
  assign busy          = busy_q;

endmodule
